rvvi_retire_buffer: RTL and testbench
=====================================

RVVI_RETIRE_BUFFER -- requirements
Module: rvvi_retire_buffer

Interface
REQ-001 Parameter XLEN, default 64, width of PC field.
REQ-002 Parameter DEPTH, default 8, record capacity; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  retirement record present this cycle; no backpressure to source.
REQ-006 in_order  input  64  retirement order number.
REQ-007 in_insn  input  32  instruction encoding.
REQ-008 in_pc  input  XLEN  instruction PC.
REQ-009 in_trap  input  1  instruction trapped.
REQ-010 in_mode  input  2  privilege mode.
REQ-011 out_valid  output  1  head record available.
REQ-012 out_ready  input  1  consumer (coverage sampler) accepts head record.
REQ-013 out_order / out_insn / out_pc / out_trap / out_mode  output  64/32/XLEN/1/2  head record fields.
REQ-014 count  output  $clog2(DEPTH)+1  records held.
REQ-015 overflow  output  1  sticky, a record was dropped.
REQ-016 order_err  output  1  sticky, order discontinuity seen.
REQ-017 drop_cnt  output  16  dropped-record count, saturating at 0xFFFF.
REQ-018 clear_status  input  1  clears overflow, order_err, drop_cnt.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH records; read/write pointers wrap modulo DEPTH.
REQ-020 Pop SHALL occur when out_valid && out_ready; head advances next cycle.
REQ-021 out_valid SHALL equal (count != 0); out_* fields SHALL be registered/stored data, never combinational from in_*.
REQ-022 Latency: record pushed in cycle N into an empty buffer SHALL present out_valid=1 in cycle N+1.
REQ-023 FSM states RUN and DROP; reset state RUN.
REQ-024 RUN: push SHALL occur when in_valid && (count < DEPTH || pop this cycle).
REQ-025 RUN: in_valid with count==DEPTH and no pop SHALL drop the record, set overflow, increment drop_cnt, go to DROP.
REQ-026 DROP: every in_valid SHALL be dropped and increment drop_cnt; pops continue normally.
REQ-027 DROP -> RUN SHALL occur in the cycle after count reaches 0; order check disarms on this transition.
REQ-028 Simultaneous push and pop SHALL leave count unchanged.
REQ-029 Order check: armed after first accepted record following reset or resync; each later accepted record with in_order != last_order+1 (64-bit wrap) SHALL set order_err; the record is still stored.
REQ-030 last_order SHALL update on every accepted record, including mismatching ones.
REQ-031 clear_status SHALL zero overflow, order_err, drop_cnt next cycle; a set/increment event in the same cycle SHALL win (flag=1, drop_cnt=1).
REQ-032 drop_cnt SHALL hold at 0xFFFF once saturated.

Reset
REQ-033 reset SHALL take priority over all inputs, including clear_status and in_valid.
REQ-034 On reset: pointers=0, count=0, out_valid=0, overflow=0, order_err=0, drop_cnt=0, state=RUN, order check disarmed; out_* data fields are don't-care while out_valid=0.
REQ-035 Reset asserted mid-stream SHALL discard all stored records; no pop is reported in that cycle.

Verification
REQ-036 DEPTH=4, orders 10,11,12 pushed one per cycle, out_ready=1 -> out_order 10,11,12 on cycles N+1..N+3, order_err=0, count never >1.
REQ-037 DEPTH=4, out_ready=0, push orders 1..5 -> count=4, order 5 dropped, overflow=1, drop_cnt=1, state DROP; push 6 -> drop_cnt=2.
REQ-038 From REQ-037, out_ready=1 until empty, then push order 100 -> accepted, order_err=0 (check disarmed); then push 102 -> order_err=1, record 102 still output.
REQ-039 DEPTH=4 full, in_valid and out_ready both high same cycle -> push accepted, count stays 4, overflow=0.
REQ-040 clear_status asserted in same cycle as a dropped record in DROP -> overflow=1, drop_cnt=1 next cycle; clear_status alone next -> all zero.
REQ-041 Reset with count=3 and in_valid=1 -> next cycle count=0, out_valid=0, state RUN, flags 0.

Source files
------------

// File: rtl/rvvi_retire_buffer_if.sv
// Retirement record stream into the buffer and head-record stream out to the coverage sampler.
interface rvvi_retire_buffer_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic [63:0]     in_order;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_pc;
    logic            in_trap;
    logic [1:0]      in_mode;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_order;
    logic [31:0]     out_insn;
    logic [XLEN-1:0] out_pc;
    logic            out_trap;
    logic [1:0]      out_mode;

    modport master (
        output in_valid, in_order, in_insn, in_pc, in_trap, in_mode, out_ready,
        input  out_valid, out_order, out_insn, out_pc, out_trap, out_mode
    );

    modport slave (
        input  in_valid, in_order, in_insn, in_pc, in_trap, in_mode, out_ready,
        output out_valid, out_order, out_insn, out_pc, out_trap, out_mode
    );
endinterface

// File: rtl/rvvi_retire_buffer.sv
// Circular FIFO of RVVI retirement records with overflow/drop tracking and an
// order-continuity checker. Once an overflow occurs, input is dropped until the buffer drains.
module rvvi_retire_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    rvvi_retire_buffer_if.slave        rv,
    input  logic                       clear_status,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       order_err,
    output logic [15:0]                drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [1:0]      mode;
    } rec_t;

    typedef enum logic {RUN, DROP} state_t;

    rec_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           overflow_reg, order_err_reg, armed_reg;
    logic [15:0]    drop_cnt_reg;
    logic [63:0]    last_order_reg;
    state_t         state_reg, state_next;

    logic           pop, push, drop, disarm, mismatch;
    rec_t           in_rec, head_rec;

    assign pop = (count_reg != '0) && rv.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    // Next state: leave DROP only once the buffer has fully drained
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:  if (drop) state_next = DROP;
            DROP: if (count_reg == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Per-cycle decisions
    always_comb begin
        push   = 1'b0;
        drop   = 1'b0;
        disarm = 1'b0;
        case (state_reg)
            RUN: begin
                if (rv.in_valid) begin
                    if ((count_reg != CW'(DEPTH)) || pop) push = 1'b1;
                    else                                  drop = 1'b1;
                end
            end
            DROP: begin
                drop   = rv.in_valid;
                disarm = (count_reg == '0);
            end
            default: ;
        endcase
    end

    assign mismatch = push && armed_reg && (rv.in_order != (last_order_reg + 64'd1));

    assign in_rec = '{order: rv.in_order, insn: rv.in_insn, pc: rv.in_pc,
                      trap: rv.in_trap, mode: rv.in_mode};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            order_err_reg  <= 1'b0;
            drop_cnt_reg   <= '0;
            armed_reg      <= 1'b0;
            last_order_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (push) begin
                armed_reg      <= 1'b1;
                last_order_reg <= rv.in_order;
            end else if (disarm) begin
                armed_reg      <= 1'b0;
            end

            // A new event in the same cycle as clear_status takes precedence over the clear
            overflow_reg  <= drop     | (overflow_reg  & ~clear_status);
            order_err_reg <= mismatch | (order_err_reg & ~clear_status);
            if (drop) begin
                if (clear_status)       drop_cnt_reg <= 16'd1;
                else if (~&drop_cnt_reg) drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end else if (clear_status) begin
                drop_cnt_reg <= '0;
            end
        end
    end

    assign head_rec     = mem[rd_ptr_reg];
    assign rv.out_valid = (count_reg != '0);
    assign rv.out_order = head_rec.order;
    assign rv.out_insn  = head_rec.insn;
    assign rv.out_pc    = head_rec.pc;
    assign rv.out_trap  = head_rec.trap;
    assign rv.out_mode  = head_rec.mode;

    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign order_err = order_err_reg;
    assign drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_rvvi_retire_buffer.sv
// Randomized + directed scoreboard bench for rvvi_retire_buffer against a queue-based reference model.
module tb_rvvi_retire_buffer;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_status;
    logic [2:0]  count;
    logic        overflow, order_err;
    logic [15:0] drop_cnt;

    rvvi_retire_buffer_if #(.XLEN(XLEN)) rv ();

    rvvi_retire_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rv           (rv),
        .clear_status (clear_status),
        .count        (count),
        .overflow     (overflow),
        .order_err    (order_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic            trap;
        logic [1:0]      mode;
    } rec_t;

    rec_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 0;

    bit          m_drop_mode, m_armed, m_overflow, m_order_err;
    logic [63:0] m_last;
    int          m_drop_cnt;
    logic [63:0] next_ord;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares status every cycle and the head record whenever a pop happens
    always @(negedge clk) begin
        if (mon_en) begin
            check("count",     64'(count),     64'(exp_q.size()));
            check("out_valid", 64'(rv.out_valid), 64'(exp_q.size() != 0));
            check("overflow",  64'(overflow),  64'(m_overflow));
            check("order_err", 64'(order_err), 64'(m_order_err));
            check("drop_cnt",  64'(drop_cnt),  64'(m_drop_cnt));
            if (!reset && rv.out_valid && rv.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_when_empty", 64'(1), 64'(0));
                end else begin
                    check("out_order", rv.out_order, exp_q[0].order);
                    check("out_insn",  64'(rv.out_insn), 64'(exp_q[0].insn));
                    check("out_pc",    64'(rv.out_pc),   64'(exp_q[0].pc));
                    check("out_trap",  64'(rv.out_trap), 64'(exp_q[0].trap));
                    check("out_mode",  64'(rv.out_mode), 64'(exp_q[0].mode));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drives one cycle of stimulus and advances the reference model at the clock edge
    task automatic cycle(input bit v, input logic [63:0] ord, input bit rdy,
                         input bit clr, input bit rst);
        rec_t r;
        int   sz;
        bit   pop, acc, drp, ev, prev_drop;
        r.order = ord;
        r.insn  = $urandom;
        r.pc    = XLEN'({$urandom, $urandom});
        r.trap  = 1'($urandom_range(0, 1));
        r.mode  = 2'($urandom_range(0, 3));
        rv.in_valid  = v;
        rv.in_order  = r.order;
        rv.in_insn   = r.insn;
        rv.in_pc     = r.pc;
        rv.in_trap   = r.trap;
        rv.in_mode   = r.mode;
        rv.out_ready = rdy;
        clear_status = clr;
        reset        = rst;

        sz  = exp_q.size();
        pop = rdy && (sz > 0);
        acc = 0;
        drp = 0;
        if (!rst) begin
            if (!m_drop_mode) begin
                if (v) begin
                    if (sz < DEPTH || pop) acc = 1;
                    else                   drp = 1;
                end
            end else begin
                drp = v;
            end
        end

        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_drop_mode = 0; m_armed = 0;
            m_overflow = 0; m_order_err = 0; m_drop_cnt = 0;
        end else begin
            ev = 0;
            if (acc) begin
                if (m_armed && ord != m_last + 64'd1) ev = 1;
                m_last  = ord;
                m_armed = 1;
                exp_q.push_back(r);
            end
            prev_drop = m_drop_mode;
            if (prev_drop && sz == 0) begin
                m_drop_mode = 0;
                m_armed     = 0;
            end else if (!prev_drop && drp) begin
                m_drop_mode = 1;
            end
            m_overflow  = drp | (m_overflow & !clr);
            m_order_err = ev  | (m_order_err & !clr);
            if (drp)      m_drop_cnt = clr ? 1 : ((m_drop_cnt == 65535) ? 65535 : m_drop_cnt + 1);
            else if (clr) m_drop_cnt = 0;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 64'd0, rdy, 0, 0);
    endtask

    initial begin
        m_drop_mode = 0; m_armed = 0; m_overflow = 0; m_order_err = 0;
        m_drop_cnt = 0; m_last = '0;
        cycle(0, 64'd0, 0, 0, 1);
        mon_en = 1;
        cycle(1, 64'd77, 1, 1, 1);          // reset beats clear_status and in_valid
        idle(1, 1);

        // Back-to-back stream with consumer always ready
        for (int i = 10; i <= 12; i++) cycle(1, 64'(i), 1, 0, 0);
        idle(2, 1);

        // Fill with consumer stalled, then overflow and keep dropping
        cycle(0, 64'd0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) cycle(1, 64'(i), 0, 0, 0);
        cycle(1, 64'd6, 0, 0, 0);
        idle(6, 1);                          // drain, leave DROP
        cycle(1, 64'd100, 1, 0, 0);          // resync: no order error
        cycle(1, 64'd102, 1, 0, 0);          // discontinuity
        idle(2, 1);

        // Full buffer with simultaneous push and pop
        cycle(0, 64'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 64'(103 + i), 0, 0, 0);
        cycle(1, 64'd107, 1, 0, 0);
        cycle(1, 64'd108, 0, 0, 0);          // overflow into DROP
        cycle(1, 64'd109, 0, 1, 0);          // drop wins over clear
        cycle(0, 64'd0, 0, 1, 0);            // clear alone
        idle(6, 1);

        // Reset mid-stream with records held
        for (int i = 0; i < 3; i++) cycle(1, 64'(200 + i), 0, 0, 0);
        cycle(1, 64'd203, 1, 0, 1);
        idle(1, 1);

        // 64-bit order wrap is continuous
        cycle(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        cycle(1, 64'd0, 1, 0, 0);
        idle(2, 1);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) cycle(1, 64'(1 + i), 0, 0, 0);
        for (int i = 0; i < 65540; i++) cycle(1, 64'd9, 0, 0, 0);
        cycle(1, 64'd9, 0, 1, 0);
        idle(6, 1);

        // Randomized traffic
        cycle(0, 64'd0, 0, 0, 1);
        next_ord = 64'd500;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] o;
            o = ($urandom_range(0, 99) < 5) ? {32'd0, $urandom} : next_ord;
            next_ord = o + 64'd1;
            cycle($urandom_range(0, 99) < 60, o, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2);
        end
        idle(DEPTH + 4, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
